chanel_result_packer: RTL



---
 rtl/chanel_result_packer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/chanel_result_packer.sv
// Gathers one rounded result per channel into a frame, buffers frames in a small FIFO,
// and streams them out word by word (channel 0 first) on a valid/ready interface.

module chanel_result_packer_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic             clr,
    input  logic [WIDTH-1:0] data,
    output logic             pending,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] hold;

    always_ff @(posedge clk) begin
        if (rst)      pending <= 1'b0;
        else if (clr) pending <= 1'b0;
        else if (vld) pending <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (vld) hold <= data;
    end

    // A strobe on the completing cycle bypasses the holding register.
    assign word = vld ? data : hold;
endmodule

module chanel_result_packer #(
    parameter int WIDTH   = 32,
    parameter int C       = 4,
    parameter int DEPTH   = 4,
    parameter int FRAME_W = 8,
    parameter int DROP_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C-1:0]           i_vld,
    input  logic [C*WIDTH-1:0]     i_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(C)-1:0]   o_chan,
    output logic                   o_last,
    output logic [FRAME_W-1:0]     o_frame,
    output logic                   o_overrun,
    output logic [DROP_W-1:0]      o_drop_cnt
);
    localparam int CW = $clog2(C);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(C - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [FRAME_W-1:0]          seq;
        logic [C-1:0][WIDTH-1:0]     data;
    } frame_t;

    logic [C-1:0]            pending;
    logic [C-1:0][WIDTH-1:0] words;
    logic                    complete;

    for (genvar k = 0; k < C; k++) begin : g_lane
        chanel_result_packer_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .vld     (i_vld[k]),
            .clr     (complete),
            .data    (i_data[k*WIDTH +: WIDTH]),
            .pending (pending[k]),
            .word    (words[k])
        );
    end

    assign complete = &(pending | i_vld);

    frame_t             mem [DEPTH];
    frame_t             head;
    logic [AW:0]        wr_ptr, rd_ptr, count;
    logic [CW-1:0]      idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic               xfer, pop, push, drop;

    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign o_valid = (count != '0);
    assign o_data  = head.data[idx];
    assign o_chan  = idx;
    assign o_last  = o_valid && (idx == LAST_IDX);
    assign o_frame = head.seq;

    // Occupancy is judged after this cycle's pop, so a full FIFO that is
    // releasing its head can still take a new frame.
    assign xfer = o_valid && o_ready;
    assign pop  = xfer && (idx == LAST_IDX);
    assign push = complete && ((count != FULL_CNT) || pop);
    assign drop = complete && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            idx        <= '0;
            frame_cnt  <= '0;
            o_overrun  <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (xfer) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (complete) frame_cnt <= frame_cnt + 1'b1;
            if (|(i_vld & pending)) o_overrun <= 1'b1;
            if (drop && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{seq: frame_cnt, data: words};
    end
endmodule
